// File: rtl/dmem_access_unit.sv
// MEM-stage initiator for a word-addressed data memory.
// Handles byte/half/word loads with extension, byte/half stores via read-modify-write, and access error reporting.
module dmem_access_unit #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic [ADDR_W-1:0] DataAdr,
    output logic [31:0]       DataIn,
    output logic              DMemW,
    output logic              DMemR,
    input  logic [31:0]       DataOut
);

    typedef enum logic [2:0] {
        IDLE, LD, ST, RMW_RD, RMW_WR, ERR, RESP
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  size_q, lane_q;
    logic        sign_q;
    logic [31:0] wdata_q;

    logic is_half, is_word, mis, oor;

    assign is_half = (req_size == 2'b01);
    assign is_word = req_size[1];
    assign mis     = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    assign oor     = |req_addr[31:ADDR_W+2];

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        if (size == 2'b00)
            r[{lane, 3'b000} +: 8] = wd[7:0];
        else if (lane[1])
            r[31:16] = wd[15:0];
        else
            r[15:0] = wd[15:0];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (mis || oor)   state_nx = ERR;
                    else if (!req_we) state_nx = LD;
                    else if (is_word) state_nx = ST;
                    else              state_nx = RMW_RD;
                end
            end
            LD, ST, RMW_WR, ERR: state_nx = RESP;
            RMW_RD:              state_nx = RMW_WR;
            RESP:                state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign DMemR      = (state == LD) || (state == RMW_RD);
    // Gating with rst keeps a write in the reset cycle from committing.
    assign DMemW      = ((state == ST) || (state == RMW_WR)) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q     <= '0;
            lane_q     <= '0;
            sign_q     <= 1'b0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= '0;
            DataAdr    <= '0;
            DataIn     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q   <= req_size;
                        lane_q   <= req_addr[1:0];
                        sign_q   <= req_signed;
                        wdata_q  <= req_wdata;
                        resp_err <= {oor, mis};
                        if (!(mis || oor)) begin
                            DataAdr <= req_addr[ADDR_W+1:2];
                            if (req_we && is_word)
                                DataIn <= req_wdata;
                        end
                    end
                end
                LD:                  resp_rdata <= extend(DataOut, size_q, lane_q, sign_q);
                RMW_RD:              DataIn     <= merge(DataOut, wdata_q, size_q, lane_q);
                ST, RMW_WR, ERR:     resp_rdata <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table, random accesses against a
// byte-array reference model, and hand-written back-to-back and mid-access reset sequences.
module tb_dmem_access_unit;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_signed;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;
    logic [ADDR_W-1:0] DataAdr;
    logic [31:0]       DataIn, DataOut;
    logic              DMemW, DMemR;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .DataAdr(DataAdr), .DataIn(DataIn),
        .DMemW(DMemW), .DMemR(DMemR), .DataOut(DataOut)
    );

    // Word-addressed DMem with asynchronous read.
    logic [31:0] dmem [32];
    logic        mem_init = 1'b1;
    assign DataOut = dmem[DataAdr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) dmem[i] <= '0;
        end else if (DMemW) begin
            dmem[DataAdr] <= DataIn;
        end
    end

    logic [7:0] ref_b [128];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [1:0] m_err(input logic [1:0] sz, input logic [31:0] a);
        logic mis, oor;
        mis = (a % nbytes(sz)) != 0;
        oor = a > 32'd127;
        return {oor, mis};
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_b[int'(a) + i] = 8'(wd >> (8 * i));
    endtask

    function automatic logic [31:0] m_word(input logic [6:0] a);
        int b;
        b = int'(a) & ~3;
        return {ref_b[b + 3], ref_b[b + 2], ref_b[b + 1], ref_b[b]};
    endfunction

    task automatic run_acc(input logic we, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic [1:0] er, output int lat,
                           output int nw, output int nr, output logic [31:0] wdat,
                           output logic [ADDR_W-1:0] wadr, output logic ok);
        int g;
        ok = 1'b1; rd = '0; er = '0; lat = 1; nw = 0; nr = 0; wdat = '0; wadr = '0;
        @(negedge clk);
        req_we = we; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) ok = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        g = 0;
        while (g < 10) begin
            @(negedge clk);
            if (resp_valid) break;
            if (DMemW) begin
                nw++;
                wdat = DataIn;
                wadr = DataAdr;
            end
            if (DMemR) nr++;
            lat++;
            g++;
        end
        if (!resp_valid) ok = 1'b0;
        else begin
            rd = resp_rdata;
            er = resp_err;
        end
    endtask

    task automatic do_check(input string name, input logic we, input logic [1:0] sz,
                            input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic [1:0] exp_er,
                            input int exp_lat, input logic [31:0] exp_word);
        logic [31:0] rd, wdat;
        logic [1:0]  er;
        logic [ADDR_W-1:0] wadr;
        int lat, nw, nr, exp_nw, exp_nr;
        logic ok;
        run_acc(we, sz, sgn, a, wd, rd, er, lat, nw, nr, wdat, wadr, ok);
        exp_nw = (we && exp_er == 2'b00) ? 1 : 0;
        exp_nr = (exp_er == 2'b00 && (!we || sz < 2'd2)) ? 1 : 0;
        chk($sformatf("%s completes", name), 32'(ok), 32'd1);
        chk($sformatf("%s resp_rdata", name), rd, exp_rd);
        chk($sformatf("%s resp_err", name), 32'(er), 32'(exp_er));
        chk($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s DMemW cycles", name), 32'(nw), 32'(exp_nw));
        chk($sformatf("%s DMemR cycles", name), 32'(nr), 32'(exp_nr));
        if (exp_nw == 1) begin
            chk($sformatf("%s DataIn", name), wdat, exp_word);
            chk($sformatf("%s DataAdr", name), 32'(wadr), 32'(a[6:2]));
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  er;
        int          lat;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [31:0] a, wd, exp_rd, w8, w12, w16, bad;
        logic [1:0]  sz, er;
        logic        we, sgn, any_resp;
        logic [5:0]  rdy, rv;
        int          lat;

        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0,        2'b00, 2};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 2'b00, 2};
        tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h09, 32'h00000012, 32'h0,        2'b00, 3};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDEAD12EF, 2'b00, 2};
        tbl[4]  = '{1'b1, 2'b10, 1'b0, 32'h0C, 32'h80F07F81, 32'h0,        2'b00, 2};
        tbl[5]  = '{1'b0, 2'b00, 1'b1, 32'h0C, 32'h0,        32'hFFFFFF81, 2'b00, 2};
        tbl[6]  = '{1'b0, 2'b00, 1'b0, 32'h0C, 32'h0,        32'h00000081, 2'b00, 2};
        tbl[7]  = '{1'b0, 2'b01, 1'b1, 32'h0E, 32'h0,        32'hFFFF80F0, 2'b00, 2};
        tbl[8]  = '{1'b0, 2'b01, 1'b0, 32'h0E, 32'h0,        32'h000080F0, 2'b00, 2};
        tbl[9]  = '{1'b0, 2'b01, 1'b1, 32'h05, 32'h0,        32'h0,        2'b01, 2};
        tbl[10] = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'h0,        2'b10, 2};
        tbl[11] = '{1'b1, 2'b01, 1'b0, 32'h0A, 32'hAAAA5555, 32'h0,        2'b00, 3};
        tbl[12] = '{1'b0, 2'b11, 1'b1, 32'h08, 32'h0,        32'h555512EF, 2'b00, 2};
        tbl[13] = '{1'b1, 2'b10, 1'b0, 32'h0E, 32'h12345678, 32'h0,        2'b01, 2};
        tbl[14] = '{1'b0, 2'b01, 1'b0, 32'h81, 32'h0,        32'h0,        2'b11, 2};
        tbl[15] = '{1'b0, 2'b00, 1'b1, 32'h0F, 32'h0,        32'hFFFFFF80, 2'b00, 2};
        tbl[16] = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0,        2'b00, 2};
        tbl[17] = '{1'b1, 2'b00, 1'b0, 32'h80, 32'h000000AA, 32'h0,        2'b10, 2};

        for (int i = 0; i < 128; i++) ref_b[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        @(posedge clk);
        #1 mem_init = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset DataAdr", 32'(DataAdr), 32'd0);
        chk("reset DataIn", DataIn, 32'h0);
        chk("reset strobes", {30'd0, DMemW, DMemR}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].we && m_err(tbl[i].sz, tbl[i].a) == 2'b00)
                m_store(tbl[i].sz, tbl[i].a, tbl[i].wd);
            do_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].sz, tbl[i].sgn, tbl[i].a,
                     tbl[i].wd, tbl[i].rd, tbl[i].er, tbl[i].lat, m_word(tbl[i].a[6:0]));
        end

        for (int i = 0; i < 300; i++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            er     = m_err(sz, a);
            exp_rd = (!we && er == 2'b00) ? m_load(sz, sgn, a) : 32'h0;
            lat    = (er == 2'b00 && we && sz < 2'd2) ? 3 : 2;
            if (we && er == 2'b00) m_store(sz, a, wd);
            do_check($sformatf("rnd%0d", i), we, sz, sgn, a, wd, exp_rd, er, lat, m_word(a[6:0]));
        end

        // Back-to-back: req_valid stays high, second request waits for req_ready.
        w8  = m_word(7'h08);
        w12 = m_word(7'h0C);
        rdy = '0; rv = '0;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h08; req_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            rdy[c] = req_ready;
            rv[c]  = resp_valid;
            if (c == 1) req_addr = 32'h0C;
            if (c == 2) chk("b2b first rdata", resp_rdata, w8);
            if (c == 4) req_valid = 1'b0;
            if (c == 5) chk("b2b second rdata", resp_rdata, w12);
        end
        chk("b2b req_ready pattern", 32'(rdy), 32'b001001);
        chk("b2b resp_valid pattern", 32'(rv), 32'b100100);

        // Reset asserted while the SH write phase is on the bus.
        w16 = m_word(7'h10);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 32'h10;
        req_wdata = 32'h0000BEEF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst-mid RMW_RD DMemR", 32'(DMemR), 32'd1);
        @(negedge clk);
        chk("rst-mid RMW_WR DMemW before rst", 32'(DMemW), 32'd1);
        rst = 1'b1;
        #1 chk("rst-mid DMemW gated", 32'(DMemW), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst-mid idle req_ready", 32'(req_ready), 32'd1);
        any_resp = resp_valid;
        repeat (4) begin
            @(negedge clk);
            any_resp = any_resp | resp_valid;
        end
        chk("rst-mid no resp_valid", 32'(any_resp), 32'd0);
        chk("rst-mid memory unchanged", dmem[4], w16);
        do_check("rst-mid reload", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, w16, 2'b00, 2, 32'h0);

        bad = '0;
        for (int i = 0; i < 32; i++) if (dmem[i] !== m_word(7'(i * 4))) bad++;
        chk("final memory image mismatching words", bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
